// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline WB stage has priority, and LLU results wait in a
// one-entry hold register. A starvation counter eventually forces the held result in ahead of the pipe.
module wb_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_dat_i,
  input  logic        llu_valid_i,
  input  logic [4:0]  llu_rd_i,
  input  logic [31:0] llu_dat_i,
  output logic        llu_ready_o,
  output logic        pipe_stall_o,
  output logic        hold_valid_o,
  output logic [4:0]  hold_rd_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  // state | meaning
  // IDLE  | hold register empty, LLU may hand over a result
  // PEND  | hold full, result losing arbitration to the pipe (counted)
  // FORCE | hold full, starvation limit reached: hold wins, pipe stalls
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [4:0]        r_hold_rd, w_hold_rd_nxt;
  logic [31:0]       r_hold_dat, w_hold_dat_nxt;
  logic              r_we, w_we_nxt;
  logic [4:0]        r_waddr, w_waddr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              w_hs;

  assign llu_ready_o  = (r_state == IDLE);
  assign hold_valid_o = (r_state != IDLE);
  assign hold_rd_o    = r_hold_rd;
  assign rf_we_o      = r_we;
  assign rf_waddr_o   = r_waddr;
  assign rf_wdata_o   = r_wdata;
  assign w_hs         = llu_valid_i & llu_ready_o;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hold_rd_nxt  = r_hold_rd;
    w_hold_dat_nxt = r_hold_dat;
    w_we_nxt       = 1'b0;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    pipe_stall_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pipe_valid_i) begin
          w_we_nxt    = (pipe_rd_i != 5'd0);
          w_waddr_nxt = pipe_rd_i;
          w_wdata_nxt = pipe_dat_i;
          // An LLU result aimed at the same rd is older than this pipe write: drop it.
          if (w_hs && (llu_rd_i != 5'd0) && (llu_rd_i != pipe_rd_i)) begin
            w_hold_rd_nxt  = llu_rd_i;
            w_hold_dat_nxt = llu_dat_i;
            w_cnt_nxt      = '0;
            w_state_nxt    = PEND;
          end
        end else if (w_hs) begin
          w_we_nxt    = (llu_rd_i != 5'd0);
          w_waddr_nxt = llu_rd_i;
          w_wdata_nxt = llu_dat_i;
        end
      end
      PEND: begin
        if (pipe_valid_i) begin
          w_we_nxt    = (pipe_rd_i != 5'd0);
          w_waddr_nxt = pipe_rd_i;
          w_wdata_nxt = pipe_dat_i;
          if (pipe_rd_i == r_hold_rd) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else if ((r_cnt + CNT_W'(1)) >= CNT_MAX) begin
            w_cnt_nxt   = CNT_MAX;
            w_state_nxt = FORCE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_hold_rd;
          w_wdata_nxt = r_hold_dat;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      FORCE: begin
        pipe_stall_o = pipe_valid_i;
        w_we_nxt     = 1'b1;
        w_waddr_nxt  = r_hold_rd;
        w_wdata_nxt  = r_hold_dat;
        w_cnt_nxt    = '0;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold_rd  <= 5'd0;
      r_hold_dat <= 32'd0;
      r_we       <= 1'b0;
      r_waddr    <= 5'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold_rd  <= w_hold_rd_nxt;
      r_hold_dat <= w_hold_dat_nxt;
      r_we       <= w_we_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic, all checked against a
// queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int SMAX = 4;

  logic        clk_i, rst_n_i;
  logic        pipe_valid_i, llu_valid_i;
  logic [4:0]  pipe_rd_i, llu_rd_i;
  logic [31:0] pipe_dat_i, llu_dat_i;
  logic        llu_ready_o, pipe_stall_o, hold_valid_o, rf_we_o;
  logic [4:0]  hold_rd_o, rf_waddr_o;
  logic [31:0] rf_wdata_o;

  wb_port_arbiter #(.STARVE_MAX(SMAX), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .pipe_valid_i(pipe_valid_i), .pipe_rd_i(pipe_rd_i), .pipe_dat_i(pipe_dat_i),
    .llu_valid_i(llu_valid_i), .llu_rd_i(llu_rd_i), .llu_dat_i(llu_dat_i),
    .llu_ready_o(llu_ready_o), .pipe_stall_o(pipe_stall_o),
    .hold_valid_o(hold_valid_o), .hold_rd_o(hold_rd_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
  } ent_t;

  ent_t m_hold[$];
  int   m_losses;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   g_exp_stall, g_exp_hs, g_obs_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hold.delete();
    m_losses = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, predict the write, check it after the edge.
  task automatic step(input bit pv, input logic [4:0] prd, input logic [31:0] pdat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit          held, forced;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_dat;
    pipe_valid_i = pv; pipe_rd_i = prd; pipe_dat_i = pdat;
    llu_valid_i  = lv; llu_rd_i  = lrd; llu_dat_i  = ldat;
    #1;
    held        = (m_hold.size() != 0);
    forced      = held && (m_losses >= SMAX);
    g_exp_stall = forced && pv;
    g_exp_hs    = lv && !held;
    g_obs_stall = pipe_stall_o;
    check_eq("llu_ready", llu_ready_o, !held);
    check_eq("pipe_stall", pipe_stall_o, g_exp_stall);
    check_eq("hold_valid", hold_valid_o, held);
    if (held) check_eq("hold_rd", hold_rd_o, m_hold[0].rd);
    e_we = 1'b0; e_addr = 5'd0; e_dat = 32'd0;
    if (forced || (held && !pv)) begin
      e_we = 1'b1; e_addr = m_hold[0].rd; e_dat = m_hold[0].dat;
      void'(m_hold.pop_front());
      m_losses = 0;
    end else if (pv) begin
      e_we = (prd != 5'd0); e_addr = prd; e_dat = pdat;
      if (held) begin
        if (m_hold[0].rd == prd) begin
          void'(m_hold.pop_front());
          m_losses = 0;
        end else begin
          m_losses++;
        end
      end else if (g_exp_hs && lrd != 5'd0 && lrd != prd) begin
        m_hold.push_back('{rd: lrd, dat: ldat});
        m_losses = 0;
      end
    end else if (g_exp_hs && lrd != 5'd0) begin
      e_we = 1'b1; e_addr = lrd; e_dat = ldat;
    end
    @(posedge clk_i);
    #1;
    check_eq("rf_we", rf_we_o, e_we);
    if (e_we) begin
      check_eq("rf_waddr", rf_waddr_o, e_addr);
      check_eq("rf_wdata", rf_wdata_o, e_dat);
    end
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n_i = 1'b0;
    #1;
    check_eq({tag, "_stall"}, pipe_stall_o, 1'b0);
    check_eq({tag, "_we"}, rf_we_o, 1'b0);
    check_eq({tag, "_hold"}, hold_valid_o, 1'b0);
    check_eq({tag, "_ready"}, llu_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_clear();
  endtask

  initial begin
    int          n_pw, stall_i;
    bit          re_pipe, llu_pend;
    bit          pv, lv;
    logic [4:0]  prd, lrd;
    logic [31:0] pdat, ldat;

    model_clear();
    rst_n_i = 1'b0;
    pipe_valid_i = 0; pipe_rd_i = 0; pipe_dat_i = 0;
    llu_valid_i = 0; llu_rd_i = 0; llu_dat_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_we", rf_we_o, 1'b0);
    check_eq("rst_ready", llu_ready_o, 1'b1);
    check_eq("rst_hold", hold_valid_o, 1'b0);
    check_eq("rst_stall", pipe_stall_o, 1'b0);
    rst_n_i = 1'b1;

    // LLU alone
    step(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
    check_eq("llu_alone_addr", rf_waddr_o, 5'd5);
    check_eq("llu_alone_dat", rf_wdata_o, 32'h1234);
    idle();

    // Collision: pipe first, LLU result one cycle later
    step(1, 5'd3, 32'hA, 1, 5'd7, 32'hB);
    check_eq("coll_first", rf_waddr_o, 5'd3);
    idle();
    check_eq("coll_second", rf_waddr_o, 5'd7);
    idle();

    // Starvation: hold x9, pipe valid every cycle
    step(1, 5'd1, 32'h11, 1, 5'd9, 32'h99);
    n_pw = 0; stall_i = -1;
    for (int i = 0; i < 8; i++) begin
      step(1, 5'(11 + i), 32'(i), 0, 5'd0, 32'd0);
      if (g_obs_stall) begin
        stall_i = i;
        break;
      end
      if (rf_we_o && rf_waddr_o == 5'(11 + i)) n_pw++;
    end
    check_eq("starve_pipe_wins", n_pw, 4);
    check_eq("starve_forced_rd", rf_waddr_o, 5'd9);
    if (stall_i >= 0) step(1, 5'(11 + stall_i), 32'(stall_i), 0, 5'd0, 32'd0);
    idle();

    // WAW: held x4 is superseded by a pipe write to x4
    step(1, 5'd2, 32'h22, 1, 5'd4, 32'h1);
    step(1, 5'd4, 32'h2, 0, 5'd0, 32'd0);
    check_eq("waw_dat", rf_wdata_o, 32'h2);
    idle();
    check_eq("waw_nowrite", rf_we_o, 1'b0);
    idle();

    // LLU write to x0 is discarded
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
    idle();

    // Async reset while in FORCE
    step(1, 5'd1, 32'h1, 1, 5'd6, 32'h66);
    for (int i = 0; i < SMAX; i++) step(1, 5'd8, 32'(i), 0, 5'd0, 32'd0);
    pipe_valid_i = 1'b1; pipe_rd_i = 5'd8;
    #1;
    check_eq("force_stall", pipe_stall_o, 1'b1);
    async_reset_check("rst_force");
    idle();
    check_eq("rst_force_nopend", rf_we_o, 1'b0);

    // Random traffic
    re_pipe = 0; llu_pend = 0;
    pv = 0; prd = 0; pdat = 0; lv = 0; lrd = 0; ldat = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset_check("rst_rand");
        re_pipe = 0; llu_pend = 0;
      end
      if (!re_pipe) begin
        pv   = ($urandom_range(0, 9) < 6);
        prd  = 5'($urandom_range(0, 7));
        pdat = $urandom;
      end
      if (!llu_pend) begin
        lv   = ($urandom_range(0, 9) < 4);
        lrd  = 5'($urandom_range(0, 7));
        ldat = $urandom;
      end
      step(pv, prd, pdat, lv, lrd, ldat);
      re_pipe  = g_exp_stall;
      llu_pend = lv && !g_exp_hs;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
